// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Branch-redirect, load-use stall and debug halt/step sequencing for a
// classic 5-stage MIPS pipeline. Turns the EX-stage redirect decision into
// PC select / PC write and the IF/ID, ID/EX flush controls.
//
// Optional feature macro: BRANCH_STATS_EN
//   defined   -> saturating redirect / stall statistics counters
//   undefined -> redirect_cnt and stall_cnt read constant zero (no flops)
module pipeline_hazard_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              id_load_use,
    input  logic              dbg_halt,
    input  logic              dbg_step,
    output logic              pc_write,
    output logic              pc_sel_target,
    output logic [ADDR_W-1:0] pc_target,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              halted,
    output logic [CNT_W-1:0]  redirect_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2,
        STEP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        flush_cnt;
    logic [2:0]        flush_cnt_next;
    logic [ADDR_W-1:0] target_reg;
    logic              take_redirect;
    logic              take_stall;

    // Next-state and combinational control outputs; reset forces a safe
    // frozen/flushed pipe regardless of the current state.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        pc_write       = 1'b0;
        pc_sel_target  = 1'b0;
        if_id_write    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        halted         = 1'b0;
        take_redirect  = 1'b0;
        take_stall     = 1'b0;
        if (!rst_n) begin
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            state_next     = RUN;
            flush_cnt_next = 3'd0;
        end else begin
            case (state)
                RUN, STEP: begin
                    if (ex_redirect) begin
                        // Redirect wins over a load-use in the same cycle:
                        // the dependent ID instruction is flushed anyway.
                        take_redirect  = 1'b1;
                        pc_write       = 1'b1;
                        pc_sel_target  = 1'b1;
                        if_id_write    = 1'b1;
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        flush_cnt_next = 3'(FLUSH_DEPTH);
                        state_next     = FLUSH;
                    end else if (id_load_use) begin
                        take_stall  = 1'b1;
                        id_ex_flush = 1'b1;
                        // A stall in STEP consumes the step.
                        if (state == STEP) begin
                            state_next = dbg_halt ? HALT : RUN;
                        end else begin
                            state_next = RUN;
                        end
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        state_next  = dbg_halt ? HALT : RUN;
                    end
                end
                FLUSH: begin
                    // EX holds a bubble, so any redirect it reports is stale.
                    if (id_load_use) begin
                        take_stall  = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                    flush_cnt_next = flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1) begin
                        flush_cnt_next = 3'd0;
                        state_next     = dbg_halt ? HALT : RUN;
                    end
                end
                HALT: begin
                    halted      = 1'b1;
                    id_ex_flush = 1'b1;
                    if (dbg_step) begin
                        state_next = STEP;
                    end else if (!dbg_halt) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // Redirect target is bypassed in the cycle it is accepted.
    assign pc_target = take_redirect ? ex_target : target_reg;

    // State, flush countdown and captured redirect target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_cnt  <= 3'd0;
            target_reg <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            if (take_redirect) begin
                target_reg <= ex_target;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (&val) begin
            return val;
        end
        return val + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [CNT_W-1:0] redirect_reg;
    logic [CNT_W-1:0] stall_reg;

    // Saturating statistics counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_reg <= '0;
            stall_reg    <= '0;
        end else begin
            if (take_redirect) begin
                redirect_reg <= sat_inc(redirect_reg);
            end
            if (take_stall) begin
                stall_reg <= sat_inc(stall_reg);
            end
        end
    end

    assign redirect_cnt = redirect_reg;
    assign stall_cnt    = stall_reg;
`else
    assign redirect_cnt = '0;
    assign stall_cnt    = '0;
`endif

endmodule
